// File: rtl/pwm_brightness_ctrl.sv
// pwm_brightness_ctrl
//   Sequences the 8-bit duty level for the PWM generator. There are three
//   requesters, in priority order:
//     1. preset load
//     2. manual quadrature-encoder steps
//     3. automatic breathing-fade engine
//   They share one working level. That level is committed to BRIGHTNESS only
//   on the last cycle of each 256-cycle frame, so the duty never changes
//   mid-frame.
//
//   Optional feature macro: PWM_GAMMA_EN
//     When defined, the commit applies a square-law gamma curve:
//     BRIGHTNESS = (level^2 + 255) >> 8.
//
// Ports
//   CLK10K        10 kHz system clock
//   RST           synchronous active-high reset
//   SW5           manual encoder enable
//   ROT_A/ROT_B   encoder phases (already synchronous)
//   FADE_EN       enable automatic breathing fade
//   PRESET_LD     one-cycle strobe: load PRESET_VAL
//   PRESET_VAL    preset level
//   BRIGHTNESS    committed duty level
//   FRAME_SYNC    high on the last cycle of each frame
//   MODE          FSM state (0 MANUAL, 1 FADE_UP, 2 HOLD_HI, 3 FADE_DOWN, 4 HOLD_LO)
//   FADE_ABORTED  fade was overridden manually; cleared while FADE_EN is low

module pwm_brightness_ctrl #(
    parameter int ROT_STEP    = 8,
    parameter int FADE_STEP   = 4,
    parameter int FADE_DIV    = 2,
    parameter int HOLD_FRAMES = 16,
    parameter int RESET_LEVEL = 255
) (
    input  logic       CLK10K,
    input  logic       RST,
    input  logic       SW5,
    input  logic       ROT_A,
    input  logic       ROT_B,
    input  logic       FADE_EN,
    input  logic       PRESET_LD,
    input  logic [7:0] PRESET_VAL,
    output logic [7:0] BRIGHTNESS,
    output logic       FRAME_SYNC,
    output logic [2:0] MODE,
    output logic       FADE_ABORTED
);

    typedef enum logic [2:0] {
        MANUAL    = 3'd0,
        FADE_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        FADE_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(FADE_DIV - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

    state_t     state, state_next;
    logic [7:0] level, level_next;
    logic [7:0] frame_cnt;
    logic [7:0] div_cnt, div_next;
    logic [7:0] hold_cnt, hold_next;
    logic       aborted, aborted_next;
    logic [1:0] prev_ab;
    logic       enc_up, enc_dn, rot_step, in_fade;
    logic [7:0] rot_up_lvl, rot_dn_lvl, fade_up_lvl, fade_dn_lvl;
    logic [8:0] rot_sum, fade_sum;
    logic [7:0] commit;

    assign FRAME_SYNC   = (frame_cnt == 8'hFF);
    assign MODE         = state;
    assign FADE_ABORTED = aborted;
    assign in_fade      = (state != MANUAL);

    // Quadrature decode on {previous AB, current AB}.
    // Illegal double-transitions fall through as no-ops.
    always_comb begin
        enc_up = 1'b0;
        enc_dn = 1'b0;
        case ({prev_ab, ROT_A, ROT_B})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: enc_up = 1'b1;
            4'b0010, 4'b0100, 4'b1101, 4'b1011: enc_dn = 1'b1;
            default: ;
        endcase
    end

    assign rot_step = SW5 && (enc_up || enc_dn);

    // 9-bit sums so that clamping at 255 and at 0 never wraps.
    assign rot_sum     = {1'b0, level} + 9'(ROT_STEP);
    assign rot_up_lvl  = (rot_sum > 9'd255) ? 8'hFF : rot_sum[7:0];
    assign rot_dn_lvl  = ({1'b0, level} < 9'(ROT_STEP)) ? 8'h00 : level - 8'(ROT_STEP);
    assign fade_sum    = {1'b0, level} + 9'(FADE_STEP);
    assign fade_up_lvl = (fade_sum > 9'd255) ? 8'hFF : fade_sum[7:0];
    assign fade_dn_lvl = ({1'b0, level} < 9'(FADE_STEP)) ? 8'h00 : level - 8'(FADE_STEP);

    always_comb begin
        state_next   = state;
        level_next   = level;
        aborted_next = aborted;
        div_next     = div_cnt;
        hold_next    = hold_cnt;
        if (PRESET_LD) begin
            level_next = PRESET_VAL;
            if (in_fade) begin
                state_next   = MANUAL;
                aborted_next = 1'b1;
            end
        end else if (rot_step) begin
            level_next = enc_up ? rot_up_lvl : rot_dn_lvl;
            if (in_fade) begin
                state_next   = MANUAL;
                aborted_next = 1'b1;
            end
        end else if (in_fade && !FADE_EN) begin
            state_next = MANUAL;
        end else if (FRAME_SYNC) begin
            case (state)
                MANUAL: begin
                    if (FADE_EN && !aborted) begin
                        state_next = FADE_UP;
                        div_next   = 8'd0;
                    end
                end
                FADE_UP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_next   = 8'd0;
                        level_next = fade_up_lvl;
                        if (fade_up_lvl == 8'hFF) begin
                            state_next = HOLD_HI;
                            hold_next  = HOLD_INIT;
                        end
                    end else begin
                        div_next = div_cnt + 8'd1;
                    end
                end
                FADE_DOWN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_next   = 8'd0;
                        level_next = fade_dn_lvl;
                        if (fade_dn_lvl == 8'h00) begin
                            state_next = HOLD_LO;
                            hold_next  = HOLD_INIT;
                        end
                    end else begin
                        div_next = div_cnt + 8'd1;
                    end
                end
                HOLD_HI: begin
                    hold_next = hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) state_next = FADE_DOWN;
                end
                HOLD_LO: begin
                    hold_next = hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) state_next = FADE_UP;
                end
                default: state_next = MANUAL;
            endcase
        end
        if (!FADE_EN) aborted_next = 1'b0;
    end

`ifdef PWM_GAMMA_EN
    logic [15:0] sq, sq_rnd;
    // Max is 255*255 + 255 = 65280, so the rounded square fits in 16 bits.
    assign sq     = 16'(level_next) * 16'(level_next);
    assign sq_rnd = sq + 16'd255;
    assign commit = sq_rnd[15:8];
`else
    assign commit = level_next;
`endif

    always_ff @(posedge CLK10K) begin
        if (RST) begin
            level      <= 8'(RESET_LEVEL);
            BRIGHTNESS <= 8'(RESET_LEVEL);
            frame_cnt  <= 8'd0;
            state      <= MANUAL;
            aborted    <= 1'b0;
            div_cnt    <= 8'd0;
            hold_cnt   <= 8'd0;
            // Track the live encoder phase so that release causes no step.
            prev_ab    <= {ROT_A, ROT_B};
        end else begin
            level     <= level_next;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= state_next;
            aborted   <= aborted_next;
            div_cnt   <= div_next;
            hold_cnt  <= hold_next;
            prev_ab   <= {ROT_A, ROT_B};
            if (FRAME_SYNC) BRIGHTNESS <= commit;
        end
    end

endmodule

// File: tb/tb_pwm_brightness_ctrl.sv
module tb_pwm_brightness_ctrl;

    logic       clk = 1'b0;
    logic       rst, sw5, rot_a, rot_b, fade_en, preset_ld;
    logic [7:0] preset_val;
    logic [7:0] brightness;
    logic       frame_sync, fade_aborted;
    logic [2:0] mode;

    pwm_brightness_ctrl dut (
        .CLK10K(clk), .RST(rst), .SW5(sw5), .ROT_A(rot_a), .ROT_B(rot_b),
        .FADE_EN(fade_en), .PRESET_LD(preset_ld), .PRESET_VAL(preset_val),
        .BRIGHTNESS(brightness), .FRAME_SYNC(frame_sync), .MODE(mode),
        .FADE_ABORTED(fade_aborted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers.
    // m_mode: 0 manual, 1 rising, 2 holding high, 3 falling, 4 holding low.
    int m_level, m_bright, m_frame, m_mode, m_abort, m_pulses, m_hold, m_prev;

    function automatic int commit(int x);
`ifdef PWM_GAMMA_EN
        return (x * x + 255) / 256;
`else
        return x;
`endif
    endfunction

    // Position of an AB pair around the quadrature cycle 00 -> 01 -> 11 -> 10.
    function automatic int gpos(int ab);
        case (ab)
            0: return 0;
            1: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int gab(int p);
        case (p % 4)
            0: return 0;
            1: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int clampi(int x);
        return (x > 255) ? 255 : ((x < 0) ? 0 : x);
    endfunction

    task automatic model_eval();
        int cur, d, nl, nmode, nab;
        bit fs;
        cur = {30'd0, rot_a, rot_b};
        if (rst) begin
            m_level = 255; m_bright = 255; m_frame = 0; m_mode = 0;
            m_abort = 0; m_pulses = 0; m_hold = 0; m_prev = cur;
            return;
        end
        fs    = (m_frame == 255);
        d     = (gpos(cur) - gpos(m_prev) + 4) % 4;   // 1 = up, 3 = down
        nl    = m_level;
        nmode = m_mode;
        nab   = m_abort;
        if (preset_ld) begin
            nl = preset_val;
            if (m_mode != 0) begin nmode = 0; nab = 1; end
        end else if (sw5 && (d == 1 || d == 3)) begin
            nl = clampi(m_level + ((d == 1) ? 8 : -8));
            if (m_mode != 0) begin nmode = 0; nab = 1; end
        end else if (m_mode != 0 && !fade_en) begin
            nmode = 0;
        end else if (fs) begin
            if (m_mode == 0) begin
                if (fade_en && !m_abort) begin nmode = 1; m_pulses = 0; end
            end else if (m_mode == 1 || m_mode == 3) begin
                m_pulses++;
                if (m_pulses == 2) begin
                    m_pulses = 0;
                    nl = clampi(m_level + ((m_mode == 1) ? 4 : -4));
                    if (nl == ((m_mode == 1) ? 255 : 0)) begin
                        nmode = m_mode + 1; m_hold = 16;
                    end
                end
            end else begin
                m_hold--;
                if (m_hold == 0) nmode = (m_mode == 2) ? 3 : 1;
            end
        end
        if (!fade_en) nab = 0;
        if (fs) m_bright = commit(nl);
        m_level = nl; m_mode = nmode; m_abort = nab;
        m_frame = (m_frame + 1) % 256;
        m_prev  = cur;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Run until the cycle that commits BRIGHTNESS has completed.
    task automatic wait_sync();
        for (int i = 0; i < 300; i++) begin
            if (frame_sync) begin
                tick();
                return;
            end
            tick();
        end
        check("sync_timeout", 0, 1);
    endtask

    typedef struct {
        bit       sw5;
        bit [1:0] ab;
        bit       ld;
        bit [7:0] val;
        bit       wsync;
        int       exp_b;
        int       exp_mode;
    } vec_t;

    function automatic vec_t mk(bit s, bit [1:0] ab, bit ld, bit [7:0] v,
                                bit w, int eb, int em);
        vec_t r;
        r.sw5 = s; r.ab = ab; r.ld = ld; r.val = v;
        r.wsync = w; r.exp_b = eb; r.exp_mode = em;
        return r;
    endfunction

    vec_t tbl[14];

    initial begin
        int k, ab;

        tbl[0]  = mk(0, 2'b00, 0, 0,   0, 255, 0);   // ignored, SW5=0
        tbl[1]  = mk(1, 2'b10, 0, 0,   0, 255, 0);   // down -> 247
        tbl[2]  = mk(1, 2'b11, 0, 0,   0, 255, 0);   // down -> 239
        tbl[3]  = mk(1, 2'b01, 0, 0,   0, 255, 0);   // down -> 231
        tbl[4]  = mk(1, 2'b00, 0, 0,   0, 255, 0);   // down -> 223, not committed
        tbl[5]  = mk(1, 2'b00, 0, 0,   1, 223, 0);   // committed at frame edge
        tbl[6]  = mk(1, 2'b00, 1, 4,   0, 223, 0);   // preset 4
        tbl[7]  = mk(1, 2'b10, 0, 0,   0, 223, 0);   // down clamps to 0
        tbl[8]  = mk(1, 2'b11, 0, 0,   1, 0,   0);   // down stays 0
        tbl[9]  = mk(1, 2'b11, 1, 250, 0, 0,   0);   // preset 250
        tbl[10] = mk(1, 2'b10, 0, 0,   1, 255, 0);   // up clamps to 255
        tbl[11] = mk(1, 2'b00, 1, 100, 1, 100, 0);   // preset wins over up step
        tbl[12] = mk(1, 2'b11, 0, 0,   1, 100, 0);   // 00->11 is a no-op
        tbl[13] = mk(0, 2'b10, 0, 0,   1, 100, 0);   // up ignored, SW5=0

        rst = 1; sw5 = 0; rot_a = 0; rot_b = 1; fade_en = 0;
        preset_ld = 0; preset_val = 0;
        tick(); tick();
        rst = 0;
        check("rst_bright", brightness, commit(255));
        check("rst_mode", mode, 0);
        check("rst_sync", frame_sync, 0);
        check("rst_abort", fade_aborted, 0);

        k = 0;
        while (!frame_sync && k < 300) begin tick(); k++; end
        check("first_sync_cycle", k, 255);
        tick();
        check("first_commit", brightness, commit(255));

        foreach (tbl[i]) begin
            sw5 = tbl[i].sw5;
            {rot_a, rot_b} = tbl[i].ab;
            preset_ld = tbl[i].ld;
            preset_val = tbl[i].val;
            tick();
            preset_ld = 0;
            if (tbl[i].wsync) wait_sync();
            check($sformatf("vec%0d_bright", i), brightness, commit(tbl[i].exp_b));
            check($sformatf("vec%0d_mode", i), mode, tbl[i].exp_mode);
        end

        // Fade from 240: four steps of 4 land on 255, one every two frames.
        sw5 = 0; preset_val = 240; preset_ld = 1; tick(); preset_ld = 0;
        fade_en = 1;
        wait_sync();
        check("fade_entry_mode", mode, 1);
        check("fade_entry_bright", brightness, commit(240));
        k = 0;
        while (mode != 2 && k < 40) begin
            wait_sync();
            k++;
            if (mode != 2) check("fade_up_mode", mode, 1);
        end
        check("frames_to_hold_hi", k, 8);
        check("hold_hi_bright", brightness, commit(255));
        k = 0;
        while (mode == 2 && k < 40) begin wait_sync(); k++; end
        check("hold_hi_frames", k, 16);
        check("fade_down_mode", mode, 3);
        wait_sync(); wait_sync();
        check("fade_down_bright", brightness, commit(251));

        // Manual up step during the fall aborts the fade and stays in manual.
        sw5 = 1; {rot_a, rot_b} = 2'b00; tick();
        check("abort_mode", mode, 0);
        check("abort_flag", fade_aborted, 1);
        wait_sync();
        check("abort_bright", brightness, commit(255));
        wait_sync();
        check("abort_no_resume", mode, 0);
        sw5 = 0; fade_en = 0; tick();
        check("abort_clear", fade_aborted, 0);
        fade_en = 1;
        wait_sync();
        check("fade_restart_mode", mode, 1);

        // Random stimulus against the model. Cycles where priority
        // interactions are ambiguous (frame edge, FADE_EN low) carry no
        // encoder or preset activity.
        for (int c = 0; c < 8000; c++) begin
            bit quiet;
            if ($urandom_range(0, 299) == 0) fade_en = ~fade_en;
            sw5 = ($urandom_range(0, 3) != 0);
            quiet = (m_frame == 255) || !fade_en;
            preset_ld = !quiet && ($urandom_range(0, 999) == 0);
            preset_val = 8'($urandom_range(0, 255));
            if (!quiet && $urandom_range(0, 49) == 0) begin
                ab = gab(gpos({30'd0, rot_a, rot_b}) + $urandom_range(1, 3));
                {rot_a, rot_b} = 2'(ab);
            end
            tick();
            check("rnd_bright", brightness, m_bright);
            check("rnd_sync", frame_sync, (m_frame == 255) ? 1 : 0);
            check("rnd_mode", mode, m_mode);
            check("rnd_abort", fade_aborted, m_abort);
        end
        preset_ld = 0;

        // Reset in the middle of a fade returns straight to manual.
        sw5 = 0; fade_en = 0; tick(); fade_en = 1;
        wait_sync();
        check("pre_reset_mode", mode, 1);
        tick();
        rst = 1; tick(); rst = 0;
        check("midfade_rst_mode", mode, 0);
        check("midfade_rst_bright", brightness, commit(255));
        check("midfade_rst_abort", fade_aborted, 0);
        check("midfade_rst_sync", frame_sync, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
